// File: rtl/ram2_pkg.sv
// Shared constants for the RAM2 instruction-side SRAM controller.
package ram2_pkg;

    localparam int unsigned RAM2_AW   = 18;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DREAD  = 3'd1;
    localparam logic [2:0] ST_WSETUP = 3'd2;
    localparam logic [2:0] ST_WPULSE = 3'd3;
    localparam logic [2:0] ST_WHOLD  = 3'd4;

endpackage

// File: rtl/ram2_ctrl.sv
// RAM2 controller: shares the single SRAM port between instruction fetch
// and MEM-stage loads/stores, stalling the front end while data accesses run.
module ram2_ctrl
    import ram2_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 1,
    parameter logic [1:0]  ADDR_HI   = 2'b00
) (
    input  logic               rci_clk,
    input  logic               rci_rst,
    input  logic [15:0]        rci_pc_addr,
    input  logic               rci_mem_req,
    input  logic               rci_mem_we,
    input  logic [15:0]        rci_mem_addr,
    input  logic [15:0]        rci_mem_wdata,
    input  logic [15:0]        rci_ram2_din,
    output logic [15:0]        rco_instr,
    output logic               rco_instr_valid,
    output logic               rco_stall,
    output logic               rco_mem_done,
    output logic [15:0]        rco_mem_rdata,
    output logic [RAM2_AW-1:0] rco_ram2_addr,
    output logic [15:0]        rco_ram2_dout,
    output logic               rco_ram2_dout_en,
    output logic               rco_ram2_en_n,
    output logic               rco_ram2_oe_n,
    output logic               rco_ram2_we_n
);

    localparam logic [1:0] CNT_LOAD = 2'(WE_CYCLES - 1);

    logic [2:0]  state_q;
    logic [1:0]  cnt_q;
    logic [15:0] hold_q;
    logic [15:0] waddr_q;
    logic [15:0] wdata_q;

    always_ff @(posedge rci_clk or negedge rci_rst) begin
        if (!rci_rst) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            hold_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (rci_mem_req) begin
                        if (rci_mem_we) begin
                            state_q <= ST_WSETUP;
                            waddr_q <= rci_mem_addr;
                            wdata_q <= rci_mem_wdata;
                        end else begin
                            state_q <= ST_DREAD;
                        end
                    end
                end
                ST_DREAD: begin
                    hold_q  <= rci_ram2_din;
                    state_q <= ST_FETCH;
                end
                ST_WSETUP: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= ST_WPULSE;
                end
                ST_WPULSE: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q <= ST_WHOLD;
                    end
                end
                ST_WHOLD: begin
                    state_q <= ST_FETCH;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

    always_comb begin
        rco_instr        = NOP_INSTR;
        rco_instr_valid  = 1'b0;
        rco_stall        = 1'b1;
        rco_mem_done     = 1'b0;
        rco_mem_rdata    = hold_q;
        rco_ram2_addr    = {ADDR_HI, rci_pc_addr};
        rco_ram2_dout    = wdata_q;
        rco_ram2_dout_en = 1'b0;
        rco_ram2_en_n    = 1'b0;
        rco_ram2_oe_n    = 1'b0;
        rco_ram2_we_n    = 1'b1;
        case (state_q)
            ST_FETCH: begin
                rco_instr       = rci_ram2_din;
                rco_instr_valid = !rci_mem_req;
                rco_stall       = rci_mem_req;
            end
            ST_DREAD: begin
                rco_ram2_addr = {ADDR_HI, rci_mem_addr};
                rco_mem_rdata = rci_ram2_din;
                rco_mem_done  = 1'b1;
            end
            ST_WSETUP, ST_WPULSE, ST_WHOLD: begin
                // Store cycle drives only the captured address/data so the
                // MEM stage may move on without disturbing the write.
                rco_ram2_addr    = {ADDR_HI, waddr_q};
                rco_ram2_dout_en = 1'b1;
                rco_ram2_oe_n    = 1'b1;
                rco_ram2_we_n    = (state_q != ST_WPULSE);
                rco_mem_done     = (state_q == ST_WHOLD);
            end
            default: begin
                rco_stall = 1'b1;
            end
        endcase
    end

    a_we_needs_dout: assert property (@(posedge rci_clk) disable iff (!rci_rst)
        !rco_ram2_we_n |-> rco_ram2_dout_en);
    a_we_addr_stable: assert property (@(posedge rci_clk) disable iff (!rci_rst)
        (!rco_ram2_we_n ##1 !rco_ram2_we_n) |-> $stable(rco_ram2_addr));

endmodule

// File: tb/tb_ram2_ctrl.sv
// Self-checking bench for ram2_ctrl with a behavioural SRAM model and a
// queue of expected read results.
module tb_ram2_ctrl;
    import ram2_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_addr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] ram2_din;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [17:0] ram2_addr;
    logic [15:0] ram2_dout;
    logic        ram2_dout_en;
    logic        ram2_en_n;
    logic        ram2_oe_n;
    logic        ram2_we_n;

    logic [15:0] sram [0:65535];
    logic [15:0] exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    ram2_ctrl #(.WE_CYCLES(2), .ADDR_HI(2'b00)) dut (
        .rci_clk         (clk),
        .rci_rst         (rst),
        .rci_pc_addr     (pc_addr),
        .rci_mem_req     (mem_req),
        .rci_mem_we      (mem_we),
        .rci_mem_addr    (mem_addr),
        .rci_mem_wdata   (mem_wdata),
        .rci_ram2_din    (ram2_din),
        .rco_instr       (instr),
        .rco_instr_valid (instr_valid),
        .rco_stall       (stall),
        .rco_mem_done    (mem_done),
        .rco_mem_rdata   (mem_rdata),
        .rco_ram2_addr   (ram2_addr),
        .rco_ram2_dout   (ram2_dout),
        .rco_ram2_dout_en(ram2_dout_en),
        .rco_ram2_en_n   (ram2_en_n),
        .rco_ram2_oe_n   (ram2_oe_n),
        .rco_ram2_we_n   (ram2_we_n)
    );

    // SRAM model: bus read is combinational, write lands while we_n is low.
    assign ram2_din = ram2_dout_en ? ram2_dout : sram[ram2_addr[15:0]];
    always @(posedge clk) begin
        if (!ram2_we_n && !ram2_en_n) sram[ram2_addr[15:0]] <= ram2_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        pc_addr = '0; mem_addr = '0; mem_wdata = '0;
        #3;
        checks++; if (ram2_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b exp 1", ram2_we_n); end
        checks++; if (ram2_dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en got %b exp 0", ram2_dout_en); end
        checks++; if (ram2_oe_n !== 1'b0 || ram2_en_n !== 1'b0) begin errors++; $display("FAIL reset_oe_en got %b%b exp 00", ram2_oe_n, ram2_en_n); end
        checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", mem_done); end
        checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", mem_rdata); end
        tick(); tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            pc_addr = 16'(i);
            exp_q.push_back(16'h1111 * 16'(i + 1));
            #2;
            e = exp_q.pop_front();
            checks++; if (instr !== e) begin errors++; $display("FAIL fetch_instr[%0d] got %h exp %h", i, instr, e); end
            checks++; if (instr_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL fetch_ctrl[%0d] got valid=%b stall=%b exp 1 0", i, instr_valid, stall); end
            tick();
        end
    endtask

    task automatic test_load();
        int unsigned stl = 0;
        bit got = 0;
        logic [15:0] e;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h8000;
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 8 && !got; i++) begin
            #2;
            if (stall) stl++;
            if (mem_done) begin
                got = 1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (mem_rdata !== e) begin errors++; $display("FAIL load_rdata got %h exp %h", mem_rdata, e); end
                checks++; if (ram2_addr !== 18'h08000) begin errors++; $display("FAIL load_addr got %h exp 08000", ram2_addr); end
                checks++; if (instr !== NOP_INSTR || instr_valid !== 1'b0) begin errors++; $display("FAIL load_nop got %h/%b exp 0800/0", instr, instr_valid); end
            end
            tick();
        end
        mem_req = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL load_timeout got no done exp done"); end
        checks++; if (stl != 2) begin errors++; $display("FAIL load_stall_cycles got %0d exp 2", stl); end
        #2;
        checks++; if (mem_rdata !== 16'hBEEF || stall !== 1'b0) begin errors++; $display("FAIL load_hold got %h stall=%b exp beef 0", mem_rdata, stall); end
        tick();
    endtask

    task automatic test_store();
        int unsigned stl = 0, den = 0, wlo = 0, bad = 0;
        bit got = 0;
        logic [15:0] e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0005; mem_wdata = 16'h1234;
        for (int i = 0; i < 12 && !got; i++) begin
            #2;
            if (stall) stl++;
            if (ram2_dout_en) den++;
            if (!ram2_we_n) wlo++;
            if (ram2_dout_en && (ram2_addr !== 18'h00005 || ram2_dout !== 16'h1234)) bad++;
            if (!ram2_we_n && !ram2_dout_en) bad++;
            if (mem_done) got = 1;
            tick();
        end
        mem_req = 1'b0; mem_we = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL store_timeout got no done exp done"); end
        checks++; if (wlo != 2) begin errors++; $display("FAIL store_we_cycles got %0d exp 2", wlo); end
        checks++; if (den != 4) begin errors++; $display("FAIL store_dout_en_cycles got %0d exp 4", den); end
        checks++; if (stl != 5) begin errors++; $display("FAIL store_stall_cycles got %0d exp 5", stl); end
        checks++; if (bad != 0) begin errors++; $display("FAIL store_bus_stable got %0d bad cycles exp 0", bad); end
        pc_addr = 16'h0005;
        exp_q.push_back(16'h1234);
        #2;
        e = exp_q.pop_front();
        checks++; if (instr !== e || instr_valid !== 1'b1) begin errors++; $display("FAIL store_readback got %h/%b exp %h/1", instr, instr_valid, e); end
        tick();
    endtask

    task automatic test_back_to_back();
        int unsigned dones = 0;
        bit prev_done = 0;
        logic [15:0] e;
        sram[16'h0100] = 16'hAAAA;
        sram[16'h0101] = 16'h5555;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0100;
        exp_q.push_back(16'hAAAA);
        exp_q.push_back(16'h5555);
        for (int i = 0; i < 12 && dones < 2; i++) begin
            #2;
            if (prev_done) begin
                checks++; if (stall !== 1'b1 || instr_valid !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("FAIL b2b_gap got stall=%b valid=%b done=%b exp 1 0 0", stall, instr_valid, mem_done); end
            end
            if (mem_done) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++; if (mem_rdata !== e) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", dones, mem_rdata, e); end
                dones++;
            end
            prev_done = mem_done;
            tick();
            if (dones == 1) mem_addr = 16'h0101;
            if (dones == 2) mem_req = 1'b0;
        end
        mem_req = 1'b0;
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", dones); end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bit found = 0;
        logic [15:0] e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h7777;
        for (int i = 0; i < 8; i++) begin
            #2;
            if (!ram2_we_n) begin found = 1; break; end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL rstw_timeout got no we_n pulse exp pulse"); end
        mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (ram2_we_n !== 1'b1 || ram2_dout_en !== 1'b0) begin errors++; $display("FAIL rstw_abort got we_n=%b dout_en=%b exp 1 0", ram2_we_n, ram2_dout_en); end
        tick(); tick();
        rst = 1'b1;
        pc_addr = 16'h0020;
        exp_q.push_back(16'h0000);
        #2;
        e = exp_q.pop_front();
        checks++; if (mem_rdata !== 16'h0000) begin errors++; $display("FAIL rstw_rdata got %h exp 0000", mem_rdata); end
        checks++; if (instr_valid !== 1'b1 || stall !== 1'b0 || ram2_we_n !== 1'b1) begin errors++; $display("FAIL rstw_fetch_state got valid=%b stall=%b we_n=%b exp 1 0 1", instr_valid, stall, ram2_we_n); end
        checks++; if (instr !== e) begin errors++; $display("FAIL rstw_no_write got %h exp %h", instr, e); end
        tick();
    endtask

    task automatic test_mem_change();
        bit changed = 0;
        bit got = 0;
        int unsigned bad = 0;
        logic [15:0] e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0033; mem_wdata = 16'hCAFE;
        for (int i = 0; i < 12 && !got; i++) begin
            #2;
            if (!ram2_we_n) changed = 1;
            if (ram2_dout_en && (ram2_addr !== 18'h00033 || ram2_dout !== 16'hCAFE)) bad++;
            if (mem_done) got = 1;
            tick();
            if (changed) begin mem_addr = 16'h0444; mem_wdata = 16'h0BAD; end
        end
        mem_req = 1'b0; mem_we = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL chg_timeout got no done exp done"); end
        checks++; if (bad != 0) begin errors++; $display("FAIL chg_captured got %0d bad cycles exp 0", bad); end
        pc_addr = 16'h0033;
        exp_q.push_back(16'hCAFE);
        #2;
        e = exp_q.pop_front();
        checks++; if (instr !== e) begin errors++; $display("FAIL chg_readback got %h exp %h", instr, e); end
        tick();
        pc_addr = 16'h0444;
        exp_q.push_back(16'h0000);
        #2;
        e = exp_q.pop_front();
        checks++; if (instr !== e) begin errors++; $display("FAIL chg_untouched got %h exp %h", instr, e); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;
        sram[0] = 16'h1111;
        sram[1] = 16'h2222;
        sram[2] = 16'h3333;
        sram[3] = 16'h4444;
        sram[16'h8000] = 16'hBEEF;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid_write();
        test_mem_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Instruction-side SRAM (RAM2) controller between the program counter and the 16-bit RAM2 chip. In normal operation it presents the PC address to RAM2 and passes the fetched word to the IF stage. When the MEM stage issues a load or store to RAM2, it arbitrates the single SRAM port, runs the read or write cycle, and holds the PC and IF/ID with `rco_stall`. Address decode that routes an access to RAM2 is done upstream; `rci_mem_req` already means "this access targets RAM2".

## Interface
- `WE_CYCLES`, default 1: number of cycles `we_n` is held low (legal range 1–4).
- `ADDR_HI`, default 2'b00: upper 2 bits of the 18-bit SRAM address.
- `rci_clk` in 1: clock; all state changes on the rising edge.
- `rci_rst` in 1: reset, asynchronous, active-low.
- `rci_pc_addr` in 16: fetch address from the PC.
- `rci_mem_req` in 1: MEM-stage RAM2 access request, level.
- `rci_mem_we` in 1: 1 = store, 0 = load; valid while `rci_mem_req` is high.
- `rci_mem_addr` in 16: data access address.
- `rci_mem_wdata` in 16: store data.
- `rci_ram2_din` in 16: SRAM data bus, read side (the tristate buffer is at the top level).
- `rco_instr` out 16: fetched instruction.
- `rco_instr_valid` out 1: `rco_instr` is a real fetch.
- `rco_stall` out 1: hold the PC (drives its enable low) and hold IF/ID.
- `rco_mem_done` out 1: the access completes at this edge.
- `rco_mem_rdata` out 16: load data.
- `rco_ram2_addr` out 18: SRAM address.
- `rco_ram2_dout` out 16: SRAM write data.
- `rco_ram2_dout_en` out 1: drive the SRAM bus.
- `rco_ram2_en_n`, `rco_ram2_oe_n`, `rco_ram2_we_n` out 1 each: SRAM controls, active-low.

## Operation
- States:
  - FETCH: default state.
  - DREAD: load cycle.
  - WSETUP, WPULSE, WHOLD: store cycle.
- FETCH:
  - SRAM signals: addr = {ADDR_HI, rci_pc_addr}, en_n=0, oe_n=0, we_n=1, dout_en=0.
  - `rco_instr` = `rci_ram2_din` (combinational); valid = !rci_mem_req.
  - Transitions: req && !we → DREAD; req && we → WSETUP; otherwise stay.
- DREAD:
  - SRAM signals: addr = {ADDR_HI, rci_mem_addr}, oe_n=0.
  - `rco_mem_rdata` = `rci_ram2_din` combinationally; the same value is latched into the hold register at the edge.
  - done=1. Next state: FETCH.
- WSETUP:
  - SRAM signals: addr = mem addr, oe_n=1, we_n=1, dout_en=1, dout = wdata.
  - Load the pulse counter with WE_CYCLES−1. Next state: WPULSE.
- WPULSE:
  - Same as WSETUP, but we_n=0.
  - Counter nonzero → decrement and stay. Zero → WHOLD.
- WHOLD:
  - we_n=1, address and data still driven. done=1. Next state: FETCH.
- Store address and data are captured into registers on entry to WSETUP. They stay stable through WHOLD even if MEM inputs change.
- `rco_stall` = (FETCH && req) || state != FETCH.
- Outside FETCH: `rco_instr` = 16'h0800 (NOP), valid=0.
- Outside DREAD: `rco_mem_rdata` = hold register.
- Requester rule: after an edge with done=1, the requester either drops `rci_mem_req` or presents the next access. A request still high in the following FETCH cycle starts a new access; no fetch is delivered that cycle.

## Timing
- Fetch: zero-cycle, combinational from `rci_pc_addr` to `rco_instr`.
- Load: 2 cycles of stall (FETCH-with-req, DREAD). Data is valid in DREAD.
- Store: 3 + WE_CYCLES cycles of stall.
- Reset (async, immediate):
  - state = FETCH, counter = 0, hold register = 0, captured addr/data = 0.
  - Outputs: we_n=1, dout_en=0, oe_n=0, en_n=0, done=0.
  - A write in progress aborts immediately; no partial re-issue after reset.
- `we_n` never goes low in the same cycle that `dout_en` rises, or in the cycle it falls. Address never changes while we_n=0.
- Back-to-back accesses always pass through one FETCH cycle. Stall stays high across it when the request is still pending.

## Structure
- Shared package `ram2_pkg`:
  - state encoding (3 bits)
  - NOP constant 16'h0800
  - SRAM address width 18
- Single module, no sub-module. Pulse counter is 2 bits, inline.
- The tristate bus is resolved at the top level from `rco_ram2_dout` and `rco_ram2_dout_en`.

## Test plan
- Reset, then pc_addr 0x0000–0x0003 with the SRAM model holding 0x1111..0x4444 → `rco_instr` follows each word, valid=1, stall=0.
- Load, mem_addr 0x8000, SRAM[0x8000]=0xBEEF → stall 2 cycles, done in DREAD, rdata=0xBEEF and held afterwards.
- Store 0x1234 to 0x0005, WE_CYCLES=2 → we_n low exactly 2 cycles, dout_en 4 cycles, addr 0x00005 stable; a later fetch of 0x0005 returns 0x1234.
- Req held high across two loads → FETCH gap cycle with stall=1 and valid=0; both loads complete with correct data.
- `rci_rst` asserted during WPULSE → we_n=1 and dout_en=0 immediately; after release, state FETCH, rdata=0.
- MEM inputs changed during WPULSE → SRAM address and data keep the values captured at WSETUP.
